// File: rtl/instr_fetch_unit_if.sv
// Bundle between the CPU control/loader side and the instruction fetch unit:
// program-load stream, control strobes, comparator input and decoded IR/PC feedback.
interface instr_fetch_unit_if #(
  parameter int unsigned OPCODE_SIZE = 4,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned IMM_WIDTH   = 8
);
  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;
  logic                   load_ready;
  logic                   load_done;
  logic                   fetch_;
  logic                   next_;
  logic                   reset_;
  logic                   halt_;
  logic                   cmp_equal;
  logic [OPCODE_SIZE-1:0] opcode;
  logic                   is_alu_operation;
  logic [IMM_WIDTH-1:0]   imm;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   halted;
  logic                   strobe_error;

  // Control FSM / program loader side.
  modport master (
    output load_valid, load_data, load_last,
    output fetch_, next_, reset_, halt_, cmp_equal,
    input  load_ready, load_done, opcode, is_alu_operation, imm, pc, halted, strobe_error
  );

  // Fetch unit side.
  modport slave (
    input  load_valid, load_data, load_last,
    input  fetch_, next_, reset_, halt_, cmp_equal,
    output load_ready, load_done, opcode, is_alu_operation, imm, pc, halted, strobe_error
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: instruction memory, program counter and instruction
// register. A program word stream fills memory in LOAD mode; in RUN mode the
// control FSM's one-hot strobes fetch into IR, advance/branch the PC, soft-reset
// PC/IR or halt the unit. HALTED is left only through the asynchronous reset.
module instr_fetch_unit #(
  parameter int unsigned OPCODE_SIZE  = 4,
  parameter int unsigned INSTR_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned IMM_WIDTH    = 8,
  parameter int unsigned ALU_OP_LIMIT = 8,
  parameter int unsigned BEQ_OP       = 12,
  parameter int unsigned BNE_OP       = 13
) (
  input logic                clock,
  input logic                reset_n,
  instr_fetch_unit_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    MODE_LOAD   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_HALTED = 2'd2
  } mode_t;

  // Branch offsets are two's complement; widen to PC width keeping the sign.
  function automatic logic [ADDR_WIDTH-1:0] sext_offset(input logic [IMM_WIDTH-1:0] v);
    return ADDR_WIDTH'($signed(v));
  endfunction

  mode_t                  mode_r, mode_nxt_s;
  logic [ADDR_WIDTH-1:0]  load_addr_r, load_addr_nxt_s;
  logic [ADDR_WIDTH-1:0]  pc_r, pc_nxt_s;
  logic [INSTR_WIDTH-1:0] ir_r;
  logic                   strobe_error_r;
  logic [INSTR_WIDTH-1:0] mem_r [DEPTH];

  logic                   mem_we_s;
  logic                   ir_load_s;
  logic                   ir_clear_s;
  logic                   err_set_s;
  logic                   any_strobe_s;
  logic                   multi_strobe_s;
  logic                   branch_taken_s;
  logic [OPCODE_SIZE-1:0] opcode_s;
  logic [IMM_WIDTH-1:0]   imm_s;

  assign opcode_s = ir_r[INSTR_WIDTH-1 -: OPCODE_SIZE];
  assign imm_s    = ir_r[IMM_WIDTH-1:0];

  assign any_strobe_s   = bus.fetch_ | bus.next_ | bus.reset_ | bus.halt_;
  assign multi_strobe_s = (bus.reset_ & bus.halt_) | (bus.reset_ & bus.fetch_) |
                          (bus.reset_ & bus.next_) | (bus.halt_ & bus.fetch_) |
                          (bus.halt_ & bus.next_)  | (bus.fetch_ & bus.next_);

  assign branch_taken_s = ((opcode_s == OPCODE_SIZE'(BEQ_OP)) &&  bus.cmp_equal) ||
                          ((opcode_s == OPCODE_SIZE'(BNE_OP)) && !bus.cmp_equal);

  // Next-state, PC update and IR control for the LOAD/RUN/HALTED mode machine.
  always_comb begin
    mode_nxt_s      = mode_r;
    load_addr_nxt_s = load_addr_r;
    pc_nxt_s        = pc_r;
    mem_we_s        = 1'b0;
    ir_load_s       = 1'b0;
    ir_clear_s      = 1'b0;
    err_set_s       = 1'b0;
    case (mode_r)
      MODE_LOAD: begin
        err_set_s = any_strobe_s;
        if (bus.load_valid) begin
          mem_we_s        = 1'b1;
          load_addr_nxt_s = load_addr_r + ADDR_ONE;
          if (bus.load_last || (load_addr_r == ADDR_LAST)) begin
            mode_nxt_s = MODE_RUN;
          end else begin
            mode_nxt_s = MODE_LOAD;
          end
        end else begin
          mem_we_s = 1'b0;
        end
      end
      MODE_RUN: begin
        err_set_s = multi_strobe_s;
        if (bus.reset_) begin
          pc_nxt_s   = ADDR_ZERO;
          ir_clear_s = 1'b1;
        end else if (bus.halt_) begin
          mode_nxt_s = MODE_HALTED;
        end else if (bus.fetch_) begin
          ir_load_s = 1'b1;
        end else if (bus.next_) begin
          if (branch_taken_s) begin
            pc_nxt_s = pc_r + sext_offset(imm_s);
          end else begin
            pc_nxt_s = pc_r + ADDR_ONE;
          end
        end else begin
          pc_nxt_s = pc_r;
        end
      end
      MODE_HALTED: begin
        mode_nxt_s = MODE_HALTED;
      end
      default: begin
        mode_nxt_s = MODE_LOAD;
        err_set_s  = 1'b1;
      end
    endcase
  end

  // Mode, load address, PC, IR and sticky error registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mode_r         <= MODE_LOAD;
      load_addr_r    <= ADDR_ZERO;
      pc_r           <= ADDR_ZERO;
      ir_r           <= INSTR_WIDTH'(0);
      strobe_error_r <= 1'b0;
    end else begin
      mode_r         <= mode_nxt_s;
      load_addr_r    <= load_addr_nxt_s;
      pc_r           <= pc_nxt_s;
      strobe_error_r <= strobe_error_r | err_set_s;
      if (ir_clear_s) begin
        ir_r <= INSTR_WIDTH'(0);
      end else if (ir_load_s) begin
        ir_r <= mem_r[pc_r];
      end else begin
        ir_r <= ir_r;
      end
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[load_addr_r] <= bus.load_data;
    end
  end

  assign bus.load_ready       = (mode_r == MODE_LOAD);
  assign bus.load_done        = (mode_r != MODE_LOAD);
  assign bus.halted           = (mode_r == MODE_HALTED);
  assign bus.strobe_error     = strobe_error_r;
  assign bus.pc               = pc_r;
  assign bus.opcode           = opcode_s;
  assign bus.imm              = imm_s;
  assign bus.is_alu_operation = (32'(opcode_s) < ALU_OP_LIMIT);

endmodule
